uart_rx_controller: RTL and testbench
=====================================

# uart_rx_controller

- Receive half of the UART peripheral; sits directly downstream of the `uart_controller` transmitter and shares its baud configuration.
- Samples the asynchronous `serial_in` line and recovers 8N1 frames: 1 start bit, `INPUT_DATA_WIDTH` data bits LSB first, 1 stop bit.
- Presents each received byte on `data_out` with a one-cycle `rx_done` pulse; malformed frames are flagged on `framing_error` instead.
- Baud rate is selected at run time through the same `baud_set_t` encoding as the transmitter, so the two can be looped back directly.

## Interface
Parameters:
- `INPUT_DATA_WIDTH`, 8, data bits per frame.
- `F_CLK`, 16000000, clock frequency in Hz; sets the bit-period divisors.

Ports:
- `clk_16mhz` input 1: the single block clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `serial_in` input 1: asynchronous UART line; idle high.
- `baud_setting` input `baud_set_t`: BAUD_SET_9600 / BAUD_SET_115200 / BAUD_SET_1000000.
- `data_out` output INPUT_DATA_WIDTH: last good byte; holds its value until the next good frame.
- `rx_done` output 1: one-cycle pulse when `data_out` has just been updated.
- `framing_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- **Bit period N (clock cycles)** = round(F_CLK/baud): 1667 (9600), 139 (115200), 16 (1000000).
- **Half period** H = N/2, truncated: 833, 69, 8.
- **Divisor latching:** N and H are latched on start detection. A `baud_setting` change mid-frame takes effect only for the next frame.
- **Synchroniser:** `serial_in` passes through a 2-FF synchroniser to give signal s. Only s is used internally.
- **Counters:** the cycle counter is wide enough for 1667; the bit index is 0..INPUT_DATA_WIDTH-1.

FSM:
- **IDLE:** when s==0, clear the counter and go to START.
- **START:** at count H-1, sample s.
  - s==0: go to DATA, clear the counter and bit index.
  - s==1: treat as a glitch and return to IDLE with no output pulse.
- **DATA:** at count N-1, shift s into the shift register MSB-side (LSB first on the line) and clear the counter. After the last bit, go to STOP.
- **STOP:** at count N-1, sample s.
  - s==1: load `data_out` from the shift register, pulse `rx_done`, go to IDLE.
  - s==0: pulse `framing_error`, leave `data_out` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until s==1, then go to IDLE. This keeps a break condition from being decoded as repeated 0x00 frames.

## Timing
- **Reset values:** state IDLE, `data_out`=0, `rx_done`=0, `framing_error`=0, `rx_busy`=0. The synchroniser flops reset to 1.
- **Reset mid-frame:** the frame is abandoned immediately and no pulse is generated. After reset release, a line that is still low is treated as a new start edge.
- **Pulses:** `rx_done` and `framing_error` are registered, exactly 1 cycle wide, and never asserted together.
- **Latency:** if the `serial_in` falling edge is captured at clock edge e, then:
  - the start sample occurs at e+2+H;
  - data bit k (0-based) is sampled at e+2+H+(k+1)·N;
  - the stop bit is sampled at e+2+H+9·N;
  - `rx_done` is high during the cycle after the stop sample.
  - The bench allows ±1 cycle.
- **Re-arm after a good frame:** the block returns to IDLE half a bit before the end of the stop bit. A start edge arriving immediately after the stop bit is therefore caught, so back-to-back frames need no idle gap.
- **Glitch rejection:** a low pulse on `serial_in` shorter than H-2 cycles never leaves START, so `rx_busy` deasserts with no output.
- **`rx_busy`:** rises the cycle after s is seen low in IDLE; falls with the return to IDLE.

## Test plan
- **Basic receive:** drive 9600-baud frames 0xD1, 0x01, 0xFF, each bit 1667 cycles, with idle high between frames -> `data_out` reads D1, 01, FF in order, one `rx_done` pulse each, `framing_error` stays 0.
- **Back-to-back:** at 115200, send 0xA5 then 0x3C with no idle gap -> two `rx_done` pulses about 10·139 cycles apart, data A5 then 3C.
- **Framing error:** at 1000000, send 0x55 with the stop bit held low, then hold the line low for 50 cycles -> one `framing_error` pulse, `data_out` keeps its prior value, no `rx_done`, block stays in WAIT_HIGH until the line rises.
- **Glitch:** at 9600, apply a 200-cycle low pulse -> no pulses, `rx_busy` returns low within 835 cycles.
- **Reset mid-frame:** assert `rstn` low during bit 3 of a frame -> all outputs 0 immediately; the next full frame 0x7E is received correctly.
- **Loopback:** connect `uart_controller.serial_out` to `serial_in` with a matching `baud_setting` at each of the three rates, and send 0xD1, 0x01, 0xFF -> each `rx_done` carries the byte sent, with no errors.

Source files
------------

// File: rtl/uart_rx_controller.sv
// UART receiver: 2-FF synchronised line input, 8N1 frame recovery with a run-time
// baud select that uses the same encoding as the transmitter.
package uart_pkg;
  typedef enum logic [1:0] {
    BAUD_SET_9600    = 2'd0,
    BAUD_SET_115200  = 2'd1,
    BAUD_SET_1000000 = 2'd2
  } baud_set_t;
endpackage

module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int F_CLK            = 16000000
) (
  input  logic                        clk_16mhz,
  input  logic                        rstn,
  input  logic                        serial_in,
  input  baud_set_t                   baud_setting,
  output logic [INPUT_DATA_WIDTH-1:0] data_out,
  output logic                        rx_done,
  output logic                        framing_error,
  output logic                        rx_busy
);

  localparam int N_9600    = (F_CLK + 4800) / 9600;
  localparam int N_115200  = (F_CLK + 57600) / 115200;
  localparam int N_1000000 = (F_CLK + 500000) / 1000000;
  localparam int CW        = $clog2(N_9600 + 1);
  localparam int BW        = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                      state, state_n;
  logic [1:0]                  sync_q;
  logic                        s;
  logic [CW-1:0]               cnt, n_lat, h_lat, n_sel;
  logic [BW-1:0]               bit_idx;
  logic [INPUT_DATA_WIDTH-1:0] shreg;
  logic                        cnt_clr, idx_clr, latch_div, shift_en, load_out, ferr;
  logic                        hit_h, hit_n;

  // Synchroniser resets to the idle-high level so reset release never looks like a start edge
  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], serial_in};
  end
  assign s = sync_q[1];

  always_comb begin
    n_sel = CW'(N_9600);
    case (baud_setting)
      BAUD_SET_115200:  n_sel = CW'(N_115200);
      BAUD_SET_1000000: n_sel = CW'(N_1000000);
      default:          n_sel = CW'(N_9600);
    endcase
  end

  assign hit_h = (cnt == h_lat - CW'(1));
  assign hit_n = (cnt == n_lat - CW'(1));

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    idx_clr   = 1'b0;
    latch_div = 1'b0;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: if (!s) begin
        state_n   = START;
        cnt_clr   = 1'b1;
        latch_div = 1'b1;
      end
      START: if (hit_h) begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
        state_n = s ? IDLE : DATA;
      end
      DATA: if (hit_n) begin
        shift_en = 1'b1;
        cnt_clr  = 1'b1;
        if (bit_idx == BW'(INPUT_DATA_WIDTH - 1)) state_n = STOP;
      end
      // Stop is judged mid-bit, so a good frame re-arms half a bit early
      STOP: if (hit_n) begin
        cnt_clr = 1'b1;
        if (s) begin
          load_out = 1'b1;
          state_n  = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      n_lat         <= CW'(N_9600);
      h_lat         <= CW'(N_9600 / 2);
      bit_idx       <= '0;
      shreg         <= '0;
      data_out      <= '0;
      rx_done       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      cnt           <= (cnt_clr || state == IDLE || state == WAIT_HIGH) ? '0 : cnt + CW'(1);
      rx_done       <= load_out;
      framing_error <= ferr;
      if (latch_div) begin
        n_lat <= n_sel;
        h_lat <= n_sel >> 1;
      end
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);
      if (shift_en) shreg    <= {s, shreg[INPUT_DATA_WIDTH-1:1]};
      if (load_out) data_out <= shreg;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: bench-side serial driver, expected-pulse queue
// drained by a negedge monitor, vector table plus hand-written corner cases.
module tb_uart_rx_controller;
  import uart_pkg::*;

  logic       clk_16mhz = 1'b0;
  logic       rstn      = 1'b0;
  logic       serial_in = 1'b1;
  baud_set_t  baud_setting = BAUD_SET_9600;
  logic [7:0] data_out;
  logic       rx_done, framing_error, rx_busy;

  uart_rx_controller #(.INPUT_DATA_WIDTH(8), .F_CLK(16000000)) dut (
    .clk_16mhz    (clk_16mhz),
    .rstn         (rstn),
    .serial_in    (serial_in),
    .baud_setting (baud_setting),
    .data_out     (data_out),
    .rx_done      (rx_done),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  int cyc = 0;
  always @(posedge clk_16mhz) cyc++;

  typedef struct {bit fe; logic [7:0] data;} exp_t;
  typedef struct {baud_set_t baud; logic [7:0] data; bit stop; bit exp_fe; logic [7:0] exp_data;} vec_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  logic [7:0] last_good = 8'h00;
  int         done_cyc = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int n_of(input baud_set_t b);
    case (b)
      BAUD_SET_115200:  return 139;
      BAUD_SET_1000000: return 16;
      default:          return 1667;
    endcase
  endfunction

  // Monitor: every pulse must match the head of the expected queue
  always @(negedge clk_16mhz) begin
    if (rx_done && framing_error) chk("pulse_overlap", 1, 0);
    if (rx_done || framing_error) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {rx_done, framing_error}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {31'd0, framing_error}, {31'd0, e.fe});
        if (rx_done) begin
          chk("rx_data", data_out, e.data);
          last_good = e.data;
          done_cyc  = cyc;
          n_done++;
        end else begin
          chk("data_hold_on_ferr", data_out, last_good);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input int n, input bit stop,
                            input baud_set_t mid, output int t0);
    @(posedge clk_16mhz); #1;
    t0 = cyc;
    serial_in = 1'b0;
    repeat (n) @(posedge clk_16mhz);
    #1;
    baud_setting = mid;
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (n) @(posedge clk_16mhz);
      #1;
    end
    serial_in = stop;
    repeat (n) @(posedge clk_16mhz);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk_16mhz);
    #1;
  endtask

  vec_t tbl[11];
  int   t0, t1, d1, d2, nb;

  initial begin
    tbl[0]  = '{BAUD_SET_9600,    8'hD1, 1'b1, 1'b0, 8'hD1};
    tbl[1]  = '{BAUD_SET_9600,    8'h01, 1'b1, 1'b0, 8'h01};
    tbl[2]  = '{BAUD_SET_9600,    8'hFF, 1'b1, 1'b0, 8'hFF};
    tbl[3]  = '{BAUD_SET_115200,  8'hD1, 1'b1, 1'b0, 8'hD1};
    tbl[4]  = '{BAUD_SET_115200,  8'h01, 1'b1, 1'b0, 8'h01};
    tbl[5]  = '{BAUD_SET_115200,  8'hFF, 1'b1, 1'b0, 8'hFF};
    tbl[6]  = '{BAUD_SET_1000000, 8'hD1, 1'b1, 1'b0, 8'hD1};
    tbl[7]  = '{BAUD_SET_1000000, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{BAUD_SET_1000000, 8'hC3, 1'b0, 1'b1, 8'h00};
    tbl[9]  = '{BAUD_SET_1000000, 8'h3C, 1'b1, 1'b0, 8'h3C};
    tbl[10] = '{BAUD_SET_1000000, 8'hFF, 1'b1, 1'b0, 8'hFF};

    // Reset state
    repeat (3) @(posedge clk_16mhz);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_busy", rx_busy, 0);
    rstn = 1'b1;
    idle(5);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      baud_setting = tbl[i].baud;
      q.push_back('{tbl[i].exp_fe, tbl[i].exp_data});
      send_frame(tbl[i].data, n_of(tbl[i].baud), tbl[i].stop, tbl[i].baud, t0);
      idle(20);
      chk($sformatf("tbl%0d_drained", i), q.size(), 0);
      chk($sformatf("tbl%0d_idle", i), rx_busy, 0);
    end

    // Latency, with a baud change after the start bit that must not affect this frame
    baud_setting = BAUD_SET_1000000;
    q.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 16, 1'b1, BAUD_SET_9600, t0);
    baud_setting = BAUD_SET_1000000;
    idle(20);
    d1 = done_cyc - t0;
    chk("latency_1m", (d1 >= 154 && d1 <= 156) ? 155 : d1, 155);
    chk("latency_drained", q.size(), 0);

    // Back-to-back at 115200, no idle gap
    baud_setting = BAUD_SET_115200;
    q.push_back('{1'b0, 8'hA5});
    q.push_back('{1'b0, 8'h3C});
    send_frame(8'hA5, 139, 1'b1, BAUD_SET_115200, t0);
    d1 = done_cyc;
    send_frame(8'h3C, 139, 1'b1, BAUD_SET_115200, t1);
    d2 = done_cyc;
    idle(20);
    chk("b2b_gap", ((d2 - d1) >= 1389 && (d2 - d1) <= 1391) ? 1390 : d2 - d1, 1390);
    chk("b2b_drained", q.size(), 0);
    chk("b2b_last", data_out, 8'h3C);

    // Framing error, line then held low
    baud_setting = BAUD_SET_1000000;
    q.push_back('{1'b1, 8'h00});
    send_frame(8'h55, 16, 1'b0, BAUD_SET_1000000, t0);
    repeat (50) @(posedge clk_16mhz);
    #1;
    chk("ferr_wait_high_busy", rx_busy, 1);
    chk("ferr_drained", q.size(), 0);
    chk("ferr_data_kept", data_out, 8'h3C);
    idle(4);
    chk("ferr_release_idle", rx_busy, 0);
    idle(20);

    // Glitch at 9600
    baud_setting = BAUD_SET_9600;
    nb = n_done;
    serial_in = 1'b0;
    t0 = cyc;
    repeat (100) @(posedge clk_16mhz);
    #1;
    chk("glitch_busy", rx_busy, 1);
    repeat (100) @(posedge clk_16mhz);
    #1;
    serial_in = 1'b1;
    while (rx_busy && (cyc - t0) < 840) begin
      @(posedge clk_16mhz);
      #1;
    end
    chk("glitch_busy_low", rx_busy, 0);
    chk("glitch_no_done", n_done, nb);
    idle(20);

    // Reset during bit 3 of a 115200 frame
    baud_setting = BAUD_SET_115200;
    serial_in = 1'b0;
    repeat (139) @(posedge clk_16mhz);
    #1;
    for (int i = 0; i < 3; i++) begin
      serial_in = (i != 0);
      repeat (139) @(posedge clk_16mhz);
      #1;
    end
    serial_in = 1'b1;
    repeat (70) @(posedge clk_16mhz);
    #1;
    chk("midrst_busy_before", rx_busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_done", rx_done, 0);
    chk("midrst_ferr", framing_error, 0);
    chk("midrst_busy", rx_busy, 0);
    last_good = 8'h00;
    repeat (5) @(posedge clk_16mhz);
    #1;
    rstn = 1'b1;
    idle(300);
    chk("midrst_no_pulse_q", q.size(), 0);
    q.push_back('{1'b0, 8'h7E});
    send_frame(8'h7E, 139, 1'b1, BAUD_SET_115200, t0);
    idle(20);
    chk("midrst_next_frame", data_out, 8'h7E);
    chk("final_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
